// File: rtl/digit_serial_addsub_pkg.sv
// Shared types and the digit adder helper for the digit-serial add/sub unit.
package digit_serial_pkg;

    typedef enum logic {
        FIRST = 1'b0,
        MID   = 1'b1
    } state_t;

    localparam int ADD_W = 32;

    typedef struct packed {
        logic             cout;
        logic             cmsb;
        logic [ADD_W-1:0] sum;
    } add_res_t;

    localparam logic [ADD_W:0] ONE = {{ADD_W{1'b0}}, 1'b1};

    // w is the live digit width; bits above w in a and b are ignored.
    function automatic add_res_t digit_add(
        input logic [ADD_W-1:0] a,
        input logic [ADD_W-1:0] b,
        input logic             cin,
        input logic [5:0]       w
    );
        logic [ADD_W:0] mask;
        logic [ADD_W:0] lmask;
        logic [ADD_W:0] full;
        logic [ADD_W:0] low;
        logic [ADD_W:0] c;
        add_res_t       r;
        mask  = (ONE << w) - ONE;
        lmask = (ONE << (w - 6'd1)) - ONE;
        c     = {{ADD_W{1'b0}}, cin};
        full  = ({1'b0, a} & mask) + ({1'b0, b} & mask) + c;
        low   = ({1'b0, a} & lmask) + ({1'b0, b} & lmask) + c;
        r.sum  = full[ADD_W-1:0] & mask[ADD_W-1:0];
        r.cout = full[w];
        r.cmsb = low[w - 6'd1];
        return r;
    endfunction

endpackage

// File: rtl/digit_serial_addsub_cell.sv
// Combinational DIGIT_W-bit add with optional B inversion.
module digit_addsub_cell
    import digit_serial_pkg::*;
#(
    parameter int DIGIT_W = 4
) (
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               inv,
    input  logic               cin,
    output logic [DIGIT_W-1:0] sum,
    output logic               cout,
    output logic               cmsb
);

    logic [ADD_W-1:0] ax;
    logic [ADD_W-1:0] bx;
    add_res_t         r;
    logic             sum_hi_unused;

    always_comb begin
        ax = '0;
        bx = '0;
        ax[DIGIT_W-1:0] = a;
        bx[DIGIT_W-1:0] = inv ? ~b : b;
        r = digit_add(ax, bx, cin, 6'(DIGIT_W));
    end

    assign sum           = r.sum[DIGIT_W-1:0];
    assign cout          = r.cout;
    assign cmsb          = r.cmsb;
    assign sum_hi_unused = ^r.sum;

endmodule

// File: rtl/digit_serial_addsub.sv
// Digit-serial adder/subtractor: LSB digit first, one registered
// result digit per valid input digit, word flags on the last digit.
module digit_serial_addsub
    import digit_serial_pkg::*;
#(
    parameter int DIGIT_W    = 4,
    parameter int MAX_DIGITS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vld,
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               sub,
    input  logic               last,
    output logic               out_vld,
    output logic [DIGIT_W-1:0] sum,
    output logic               out_last,
    output logic               carry_out,
    output logic               ovf,
    output logic               len_err
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

    state_t             state;
    state_t             state_nxt;
    logic               carry;
    logic               carry_nxt;
    logic               mode;
    logic               mode_nxt;
    logic               lerr;
    logic               lerr_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               eff_sub;
    logic               cin;
    logic               word_err;
    logic [DIGIT_W-1:0] s;
    logic               s_cout;
    logic               s_cmsb;

    // The first digit takes its mode straight from the port.
    assign eff_sub  = (state == FIRST) ? sub : mode;
    assign cin      = (state == FIRST) ? sub : carry;
    assign word_err = lerr | (cnt == CNT_MAX);

    digit_addsub_cell #(
        .DIGIT_W(DIGIT_W)
    ) u_cell (
        .a   (a),
        .b   (b),
        .inv (eff_sub),
        .cin (cin),
        .sum (s),
        .cout(s_cout),
        .cmsb(s_cmsb)
    );

    always_comb begin
        state_nxt = state;
        carry_nxt = carry;
        mode_nxt  = mode;
        lerr_nxt  = lerr;
        cnt_nxt   = cnt;
        if (vld) begin
            mode_nxt = eff_sub;
            if (last) begin
                state_nxt = FIRST;
                carry_nxt = 1'b0;
                cnt_nxt   = '0;
                lerr_nxt  = 1'b0;
            end else begin
                state_nxt = MID;
                carry_nxt = s_cout;
                cnt_nxt   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
                lerr_nxt  = word_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FIRST;
            carry     <= 1'b0;
            mode      <= 1'b0;
            lerr      <= 1'b0;
            cnt       <= '0;
            out_vld   <= 1'b0;
            sum       <= '0;
            out_last  <= 1'b0;
            carry_out <= 1'b0;
            ovf       <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            carry     <= carry_nxt;
            mode      <= mode_nxt;
            lerr      <= lerr_nxt;
            cnt       <= cnt_nxt;
            out_vld   <= vld;
            sum       <= vld ? s : '0;
            out_last  <= vld & last;
            carry_out <= vld & last & s_cout;
            ovf       <= vld & last & (s_cout ^ s_cmsb);
            len_err   <= vld & last & word_err;
        end
    end

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Bench for digit_serial_addsub: word-level arithmetic model plus
// literal checks on reassembled result words.
module tb_digit_serial_addsub;

    localparam int DW  = 4;
    localparam int MAX = 4;

    logic          clk;
    logic          rst;
    logic          vld;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          sub;
    logic          last;
    logic          out_vld;
    logic [DW-1:0] sum;
    logic          out_last;
    logic          carry_out;
    logic          ovf;
    logic          len_err;

    digit_serial_addsub #(
        .DIGIT_W   (DW),
        .MAX_DIGITS(MAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .vld      (vld),
        .a        (a),
        .b        (b),
        .sub      (sub),
        .last     (last),
        .out_vld  (out_vld),
        .sum      (sum),
        .out_last (out_last),
        .carry_out(carry_out),
        .ovf      (ovf),
        .len_err  (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int     n;
        logic   mode;
        longint wa;
        longint wb;
    } ms_t;

    typedef struct packed {
        logic       vld;
        logic       last;
        logic       cout;
        logic       ovf;
        logic       lerr;
        logic [3:0] sum;
    } ex_t;

    ms_t ms;
    ex_t ex;
    int  chk_cnt;
    int  pass_cnt;
    logic [3:0] caps[$];
    logic [2:0] flg[$];

    // Whole-word arithmetic: digit k is digit k of A + effB + mode over k+1 digits.
    function automatic void model_step(
        input  ms_t        s,
        input  logic       r,
        input  logic       v,
        input  logic [3:0] ai,
        input  logic [3:0] bi,
        input  logic       su,
        input  logic       la,
        output ms_t        ns,
        output ex_t        e
    );
        longint mask;
        longint effb;
        longint res;
        int     w;
        ns = s;
        e  = '0;
        if (r) begin
            ns.n = 0; ns.mode = 1'b0; ns.wa = 0; ns.wb = 0;
            return;
        end
        if (!v) return;
        if (s.n == 0) ns.mode = su;
        ns.wa = s.wa | (longint'(ai) << (4 * s.n));
        ns.wb = s.wb | (longint'(bi) << (4 * s.n));
        ns.n  = s.n + 1;
        w     = 4 * ns.n;
        mask  = (longint'(1) << w) - 1;
        effb  = ns.mode ? (~ns.wb & mask) : ns.wb;
        res   = ns.wa + effb + longint'(ns.mode);
        e.vld = 1'b1;
        e.sum = 4'(res >> (w - 4));
        if (la) begin
            e.last = 1'b1;
            e.cout = res[w];
            e.ovf  = (ns.wa[w-1] == effb[w-1]) && (res[w-1] != ns.wa[w-1]);
            e.lerr = ns.n > MAX;
            ns.n = 0; ns.mode = 1'b0; ns.wa = 0; ns.wb = 0;
        end
    endfunction

    always @(posedge clk) begin : mdl
        ms_t ns;
        ex_t ne;
        model_step(ms, rst, vld, a, b, sub, last, ns, ne);
        ms <= ns;
        ex <= ne;
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic dig(input logic [3:0] ai, input logic [3:0] bi,
                       input logic su, input logic la);
        @(posedge clk);
        #1;
        vld = 1'b1; a = ai; b = bi; sub = su; last = la;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            vld = 1'b0; a = '0; b = '0; sub = 1'b0; last = 1'b0;
        end
    endtask

    function automatic logic [31:0] asm_word(input int from);
        logic [31:0] w;
        w = '0;
        for (int i = from; i < caps.size(); i++)
            w = w | (32'(caps[i]) << (4 * (i - from)));
        return w;
    endfunction

    task automatic clear_caps();
        caps.delete();
        flg.delete();
    endtask

    initial begin
        chk_cnt = 0; pass_cnt = 0;
        rst = 1'b1; vld = 1'b0; a = '0; b = '0; sub = 1'b0; last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", {27'd0, out_vld, out_last, carry_out, ovf, len_err},
              32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        rst = 1'b0;

        fork
            forever begin
                @(negedge clk);
                check("cycle",
                      {23'd0, out_vld, out_last, carry_out, ovf, len_err,
                       ex.vld ? sum : 4'h0},
                      {23'd0, ex});
                if (out_vld) caps.push_back(sum);
                if (out_last) flg.push_back({carry_out, ovf, len_err});
            end
        join_none

        // 0x1234 + 0x0FCD
        clear_caps();
        dig(4'h4, 4'hD, 0, 0); dig(4'h3, 4'hC, 0, 0);
        dig(4'h2, 4'hF, 0, 0); dig(4'h1, 4'h0, 0, 1);
        idle(2);
        check("add_word", asm_word(0), 32'h2201);
        check("add_n", caps.size(), 4);
        check("add_flags", (flg.size() == 1) ? 32'(flg[0]) : 32'hFF, 32'h0);

        // 0x03 - 0x05, sub dropped mid-word
        clear_caps();
        dig(4'h3, 4'h5, 1, 0); dig(4'h0, 4'h0, 0, 1);
        idle(2);
        check("sub_word", asm_word(0), 32'hFE);
        check("sub_flags", (flg.size() == 1) ? 32'(flg[0]) : 32'hFF, 32'h0);

        // 0x7F + 0x01 signed overflow
        clear_caps();
        dig(4'hF, 4'h1, 0, 0); dig(4'h7, 4'h0, 0, 1);
        idle(2);
        check("ovf_word", asm_word(0), 32'h80);
        check("ovf_flags", (flg.size() == 1) ? 32'(flg[0]) : 32'hFF, 32'h2);

        // gaps, then back-to-back single digit 9+8
        clear_caps();
        dig(4'h4, 4'hD, 0, 0); dig(4'h3, 4'hC, 0, 0);
        idle(3);
        dig(4'h2, 4'hF, 0, 0); dig(4'h1, 4'h0, 0, 1);
        dig(4'h9, 4'h8, 0, 1);
        idle(2);
        check("gap_n", caps.size(), 5);
        check("gap_word", asm_word(0), 32'h12201);
        check("gap_flags0", (flg.size() == 2) ? 32'(flg[0]) : 32'hFF, 32'h0);
        check("single_flags", (flg.size() == 2) ? 32'(flg[1]) : 32'hFF, 32'h6);

        // length error, then a clean 2-digit word
        clear_caps();
        for (int i = 0; i < 5; i++) dig(4'h0, 4'h0, 0, (i == 4));
        dig(4'h1, 4'h2, 0, 0); dig(4'h0, 4'h0, 0, 1);
        idle(2);
        check("len_n", caps.size(), 7);
        check("len_word", asm_word(0), 32'h300000);
        check("len_flags0", (flg.size() == 2) ? 32'(flg[0]) : 32'hFF, 32'h1);
        check("len_flags1", (flg.size() == 2) ? 32'(flg[1]) : 32'hFF, 32'h0);

        // reset mid-word with vld high on the reset edge
        clear_caps();
        dig(4'h4, 4'hD, 0, 0); dig(4'h3, 4'hC, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1; vld = 1'b1; a = 4'h2; b = 4'hF; sub = 1'b0; last = 1'b0;
        @(posedge clk);
        #1;
        check("rst_out", {28'd0, out_vld, out_last, carry_out, len_err}, 32'd0);
        rst = 1'b0; vld = 1'b0;
        idle(1);
        dig(4'h1, 4'h1, 0, 0); dig(4'h0, 4'h0, 0, 0);
        dig(4'h0, 4'h0, 0, 0); dig(4'h0, 4'h0, 0, 1);
        idle(2);
        check("rst_n", caps.size(), 6);
        check("rst_word", asm_word(2), 32'h0002);
        check("rst_nlast", flg.size(), 1);
        check("rst_flags", (flg.size() == 1) ? 32'(flg[0]) : 32'hFF, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
